// File: rtl/dma_seq_ctrl_if.sv
// Register-bus bundle shared by the host port and the dma_engine master port.
// The master drives the request; the slave returns combinational read data.
interface dma_seq_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata;

    modport master (output req_valid, req_write, req_addr, req_wdata, req_wstrb, input rdata);
    modport slave  (input req_valid, req_write, req_addr, req_wdata, req_wstrb, output rdata);
endinterface

// File: rtl/dma_seq_ctrl.sv
// Descriptor-chain sequencer: walks up to NUM_DESC (src, len) descriptors,
// programming, starting, polling and clearing dma_engine for each in turn.
module dma_seq_ctrl #(
    parameter int NUM_DESC    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           rst,
    dma_seq_ctrl_if.slave  host,
    dma_seq_ctrl_if.master dma,
    output logic           seq_busy,
    output logic           seq_irq
);

    localparam int              IW       = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
    localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LIM  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [3:0]      ND_CNT   = 4'(NUM_DESC);
    localparam logic [4:0]      ND_SLOTS = 5'(NUM_DESC);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR0, S_WR_SRC, S_WR_LEN, S_WR_GO, S_POLL, S_CLR, S_NEXT
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      idx_r, idx_s;
    logic [3:0]      completed_r, completed_s;
    logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s;
    logic            poll_err_r, poll_err_s;
    logic [3:0]      count_r;
    logic            done_r, err_dma_r, err_tmo_r, aborted_r, abort_pend_r;
    logic [31:0]     desc_src_r [NUM_DESC];
    logic [31:0]     desc_len_r [NUM_DESC];

    logic            set_done_s, set_err_dma_s, set_err_tmo_s, set_aborted_s, clr_flags_s;
    logic            m_wr_s;
    logic [31:0]     m_addr_s, m_wdata_s;
    logic [7:0]      addr_s, d_off_s;
    logic [IW-1:0]   d_idx_s;
    logic            wr_s, ctrl_wr_s, start_s, abort_s, busy_s;
    logic            desc_hit_s, desc_is_len_s, desc_wr_s, count_wr_s;
    logic            unused_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign addr_s        = host.req_addr[7:0];
    assign d_off_s       = addr_s - 8'h10;
    assign d_idx_s       = d_off_s[IW+2:3];
    assign desc_hit_s    = (addr_s >= 8'h10) && (d_off_s[7:3] < ND_SLOTS) && (addr_s[1:0] == 2'b00);
    assign desc_is_len_s = addr_s[2];
    assign busy_s        = (state_r != S_IDLE);
    assign wr_s          = host.req_valid && host.req_write;
    assign ctrl_wr_s     = wr_s && (addr_s == 8'h00);
    assign start_s       = ctrl_wr_s && host.req_wdata[0];
    assign abort_s       = ctrl_wr_s && host.req_wdata[4];
    assign desc_wr_s     = wr_s && desc_hit_s && !busy_s;
    assign count_wr_s    = wr_s && (addr_s == 8'h04) && !busy_s;
    assign seq_busy      = busy_s;
    assign seq_irq       = done_r;
    assign unused_s      = ^{host.req_addr[31:8], dma.rdata[31:4], dma.rdata[0]};

    assign dma.req_valid = m_wr_s;
    assign dma.req_write = m_wr_s;
    assign dma.req_addr  = m_addr_s;
    assign dma.req_wdata = m_wdata_s;
    assign dma.req_wstrb = m_wr_s ? 4'hF : 4'h0;

    // Host read mux; unmapped offsets return zero.
    always_comb begin
        host.rdata = 32'd0;
        case (addr_s)
            8'h00:   host.rdata = {25'd0, aborted_r, err_tmo_r, 1'b0, busy_s, err_dma_r, done_r, 1'b0};
            8'h04:   host.rdata = {28'd0, count_r};
            8'h08:   host.rdata = {12'd0, completed_r, 12'd0, idx_r};
            default: begin
                if (desc_hit_s) begin
                    host.rdata = desc_is_len_s ? desc_len_r[d_idx_s] : desc_src_r[d_idx_s];
                end else begin
                    host.rdata = 32'd0;
                end
            end
        endcase
    end

    // Next-state, sequencing datapath and the single master access of this cycle.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        completed_s   = completed_r;
        tmo_cnt_s     = tmo_cnt_r;
        poll_err_s    = poll_err_r;
        set_done_s    = 1'b0;
        set_err_dma_s = 1'b0;
        set_err_tmo_s = 1'b0;
        set_aborted_s = 1'b0;
        clr_flags_s   = 1'b0;
        m_wr_s        = 1'b0;
        m_addr_s      = 32'd0;
        m_wdata_s     = 32'd0;
        case (state_r)
            S_IDLE: begin
                if (!start_s) begin
                    state_s = S_IDLE;
                end else if (count_r == 4'd0) begin
                    set_done_s = 1'b1;
                end else if (count_r > ND_CNT) begin
                    set_done_s    = 1'b1;
                    set_err_dma_s = 1'b1;
                end else begin
                    clr_flags_s = 1'b1;
                    idx_s       = 4'd0;
                    completed_s = 4'd0;
                    state_s     = S_CLR0;
                end
            end
            S_CLR0: begin
                m_wr_s    = 1'b1;
                m_addr_s  = 32'h0000_0008;
                m_wdata_s = 32'h0000_0006;
                state_s   = S_WR_SRC;
            end
            S_WR_SRC: begin
                m_wr_s    = 1'b1;
                m_addr_s  = 32'h0000_0000;
                m_wdata_s = desc_src_r[idx_r[IW-1:0]];
                state_s   = S_WR_LEN;
            end
            S_WR_LEN: begin
                m_wr_s    = 1'b1;
                m_addr_s  = 32'h0000_0004;
                m_wdata_s = desc_len_r[idx_r[IW-1:0]];
                state_s   = S_WR_GO;
            end
            S_WR_GO: begin
                m_wr_s    = 1'b1;
                m_addr_s  = 32'h0000_0008;
                m_wdata_s = 32'h0000_0001;
                tmo_cnt_s = {TW{1'b0}};
                state_s   = S_POLL;
            end
            S_POLL: begin
                m_addr_s = 32'h0000_0008;
                if (dma.rdata[1] && !dma.rdata[3]) begin
                    poll_err_s = dma.rdata[2];
                    state_s    = S_CLR;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                    // Timeout leaves dma_engine running; no clearing write is issued.
                    if (tmo_cnt_s == TMO_LIM) begin
                        set_err_tmo_s = 1'b1;
                        set_done_s    = 1'b1;
                        state_s       = S_IDLE;
                    end else begin
                        state_s = S_POLL;
                    end
                end
            end
            S_CLR: begin
                m_wr_s    = 1'b1;
                m_addr_s  = 32'h0000_0008;
                m_wdata_s = 32'h0000_0006;
                if (poll_err_r) begin
                    set_err_dma_s = 1'b1;
                    set_done_s    = 1'b1;
                    state_s       = S_IDLE;
                end else begin
                    completed_s = completed_r + 4'd1;
                    state_s     = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort_pend_r) begin
                    set_aborted_s = 1'b1;
                    set_done_s    = 1'b1;
                    state_s       = S_IDLE;
                end else if ((idx_r + 4'd1) == count_r) begin
                    set_done_s = 1'b1;
                    state_s    = S_IDLE;
                end else begin
                    idx_s   = idx_r + 4'd1;
                    state_s = S_WR_SRC;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state and sequencing datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            idx_r       <= 4'd0;
            completed_r <= 4'd0;
            tmo_cnt_r   <= {TW{1'b0}};
            poll_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            completed_r <= completed_s;
            tmo_cnt_r   <= tmo_cnt_s;
            poll_err_r  <= poll_err_s;
        end
    end

    // Sticky status flags (hardware set beats a same-cycle W1C), count and abort request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r       <= 1'b0;
            err_dma_r    <= 1'b0;
            err_tmo_r    <= 1'b0;
            aborted_r    <= 1'b0;
            abort_pend_r <= 1'b0;
            count_r      <= 4'd0;
        end else begin
            if (clr_flags_s) begin
                done_r    <= 1'b0;
                err_dma_r <= 1'b0;
                err_tmo_r <= 1'b0;
                aborted_r <= 1'b0;
            end else begin
                done_r    <= (done_r    & ~(ctrl_wr_s & host.req_wdata[1])) | set_done_s;
                err_dma_r <= (err_dma_r & ~(ctrl_wr_s & host.req_wdata[2])) | set_err_dma_s;
                err_tmo_r <= (err_tmo_r & ~(ctrl_wr_s & host.req_wdata[5])) | set_err_tmo_s;
                aborted_r <= (aborted_r & ~(ctrl_wr_s & host.req_wdata[6])) | set_aborted_s;
            end
            if (state_s == S_IDLE) begin
                abort_pend_r <= 1'b0;
            end else if (abort_s && busy_s) begin
                abort_pend_r <= 1'b1;
            end else begin
                abort_pend_r <= abort_pend_r;
            end
            if (count_wr_s) begin
                count_r <= host.req_wdata[3:0];
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Descriptor table, byte-strobed host writes accepted only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DESC; i++) begin
                desc_src_r[i] <= 32'd0;
                desc_len_r[i] <= 32'd0;
            end
        end else if (desc_wr_s) begin
            if (desc_is_len_s) begin
                desc_len_r[d_idx_s] <= merge_bytes(desc_len_r[d_idx_s], host.req_wdata, host.req_wstrb);
            end else begin
                desc_src_r[d_idx_s] <= merge_bytes(desc_src_r[d_idx_s], host.req_wdata, host.req_wstrb);
            end
        end
    end

endmodule

// File: tb/tb_dma_seq_ctrl.sv
// Scoreboard bench for dma_seq_ctrl: expected master writes and host read data are
// queued by the stimulus and popped by a negedge monitor; dma_engine is a small model.
module tb_dma_seq_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;
    logic seq_busy, seq_irq;

    dma_seq_ctrl_if host_if ();
    dma_seq_ctrl_if dma_if ();

    dma_seq_ctrl #(.NUM_DESC(4), .TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (host_if),
        .dma      (dma_if),
        .seq_busy (seq_busy),
        .seq_irq  (seq_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [68:0] exp_m [$];
    logic [31:0] exp_r [$];

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] mw(input logic [31:0] a, input logic [31:0] d);
        return {1'b1, a, d, 4'hF};
    endfunction

    // dma_engine model: odd length errors at once, otherwise busy for len cycles unless stalled.
    logic [31:0] m_src = 32'd0;
    logic [31:0] m_len = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;

    assign dma_if.rdata = (dma_if.req_addr[7:0] == 8'h08) ? {28'd0, (m_cnt != 32'd0), m_err, m_done, 1'b0} :
                          (dma_if.req_addr[7:0] == 8'h00) ? m_src :
                          (dma_if.req_addr[7:0] == 8'h04) ? m_len : 32'd0;

    always @(posedge clk) begin
        if (dma_if.req_valid && dma_if.req_write) begin
            case (dma_if.req_addr[7:0])
                8'h00: m_src <= dma_if.req_wdata;
                8'h04: m_len <= dma_if.req_wdata;
                8'h08: begin
                    if (dma_if.req_wdata[0]) begin
                        if (m_len[0]) begin
                            m_done <= 1'b1;
                            m_err  <= 1'b1;
                            m_cnt  <= 32'd0;
                        end else begin
                            m_cnt <= m_len;
                        end
                    end else begin
                        if (dma_if.req_wdata[1]) m_done <= 1'b0;
                        if (dma_if.req_wdata[2]) m_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (m_cnt != 32'd0 && !stall) begin
            m_cnt <= m_cnt - 32'd1;
            if (m_cnt == 32'd1) m_done <= 1'b1;
        end
    end

    // Monitor: compare every master write and every host read against the queues.
    always @(negedge clk) begin
        if (!rst && dma_if.req_valid) begin
            if (exp_m.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL m_unexpected: got addr %h data %h expected no access",
                         dma_if.req_addr, dma_if.req_wdata);
            end else begin
                chk("m_req", {dma_if.req_write, dma_if.req_addr, dma_if.req_wdata, dma_if.req_wstrb},
                    exp_m.pop_front());
            end
        end
        if (!rst && host_if.req_valid && !host_if.req_write) begin
            if (exp_r.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_unexpected: got %h expected no read", host_if.rdata);
            end else begin
                chk("host_rdata", 69'(host_if.rdata), 69'(exp_r.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        host_if.req_valid = 1'b1;
        host_if.req_write = 1'b1;
        host_if.req_addr  = a;
        host_if.req_wdata = d;
        host_if.req_wstrb = s;
        step();
        host_if.req_valid = 1'b0;
        host_if.req_write = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] a, input logic [31:0] e);
        exp_r.push_back(e);
        host_if.req_valid = 1'b1;
        host_if.req_write = 1'b0;
        host_if.req_addr  = a;
        step();
        host_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (seq_busy && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle", 69'(seq_busy), 69'd0);
    endtask

    task automatic wait_master(input logic [31:0] a, input logic [31:0] d, input int budget);
        int n = 0;
        while (!(dma_if.req_valid && dma_if.req_addr == a && dma_if.req_wdata == d) && n < budget) begin
            step();
            n++;
        end
        chk("wait_master", 69'(dma_if.req_valid), 69'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int polls;
        host_if.req_valid = 1'b0;
        host_if.req_write = 1'b0;
        host_if.req_addr  = 32'd0;
        host_if.req_wdata = 32'd0;
        host_if.req_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and ABORT in IDLE.
        chk("rst_busy", 69'(seq_busy), 69'd0);
        chk("rst_irq", 69'(seq_irq), 69'd0);
        chk("rst_m_valid", 69'(dma_if.req_valid), 69'd0);
        host_read(32'h00, 32'h0);
        host_read(32'h04, 32'h0);
        host_read(32'h08, 32'h0);
        host_read(32'h14, 32'h0);
        host_write(32'h00, 32'h10);
        host_read(32'h00, 32'h0);
        host_read(32'h50, 32'h0);

        // Two-descriptor chain, byte strobes, writes ignored while busy.
        host_write(32'h04, 32'd2);
        host_write(32'h10, 32'h100);
        host_write(32'h14, 32'd4);
        host_write(32'h1C, 32'd2);
        host_write(32'h18, 32'hAAAA_AAAA);
        host_write(32'h18, 32'h0000_0200, 4'b0011);
        host_read(32'h18, 32'hAAAA_0200);
        host_write(32'h18, 32'h0000_0000, 4'b1100);
        host_read(32'h18, 32'h0000_0200);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h100));
        exp_m.push_back(mw(32'h04, 32'h4));
        exp_m.push_back(mw(32'h08, 32'h1));
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h200));
        exp_m.push_back(mw(32'h04, 32'h2));
        exp_m.push_back(mw(32'h08, 32'h1));
        exp_m.push_back(mw(32'h08, 32'h6));
        host_write(32'h00, 32'h1);
        host_write(32'h10, 32'hDEAD);
        host_write(32'h04, 32'd3);
        host_read(32'h00, 32'h8);
        wait_idle(200);
        host_read(32'h00, 32'h2);
        host_read(32'h08, 32'h0002_0001);
        host_read(32'h10, 32'h100);
        host_read(32'h04, 32'h2);
        chk("irq_done", 69'(seq_irq), 69'd1);
        host_write(32'h00, 32'h2);
        host_read(32'h00, 32'h0);
        chk("irq_cleared", 69'(seq_irq), 69'd0);

        // Odd length: dma error on first poll.
        host_write(32'h04, 32'd1);
        host_write(32'h10, 32'h300);
        host_write(32'h14, 32'd3);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h300));
        exp_m.push_back(mw(32'h04, 32'h3));
        exp_m.push_back(mw(32'h08, 32'h1));
        exp_m.push_back(mw(32'h08, 32'h6));
        host_write(32'h00, 32'h1);
        wait_idle(100);
        host_read(32'h00, 32'h6);
        host_read(32'h08, 32'h0);
        host_write(32'h00, 32'h66);

        // Timeout: dma_engine held busy, exactly 16 POLL cycles, no CLR.
        stall = 1'b1;
        host_write(32'h14, 32'd4);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h300));
        exp_m.push_back(mw(32'h04, 32'h4));
        exp_m.push_back(mw(32'h08, 32'h1));
        host_write(32'h00, 32'h1);
        wait_master(32'h08, 32'h1, 20);
        step();
        polls = 0;
        while (seq_busy && polls < 40) begin
            polls++;
            step();
        end
        chk("timeout_polls", 69'(polls), 69'd16);
        host_read(32'h00, 32'h22);
        host_read(32'h08, 32'h0);
        stall = 1'b0;
        repeat (20) step();
        host_write(32'h00, 32'h66);

        // ABORT during descriptor 0 poll: finishes descriptor 0 then stops.
        host_write(32'h04, 32'd3);
        host_write(32'h10, 32'h400);
        host_write(32'h14, 32'd8);
        host_write(32'h18, 32'h500);
        host_write(32'h1C, 32'd2);
        host_write(32'h20, 32'h600);
        host_write(32'h24, 32'd2);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h400));
        exp_m.push_back(mw(32'h04, 32'h8));
        exp_m.push_back(mw(32'h08, 32'h1));
        exp_m.push_back(mw(32'h08, 32'h6));
        host_write(32'h00, 32'h1);
        wait_master(32'h08, 32'h1, 20);
        step();
        host_write(32'h00, 32'h10);
        wait_idle(100);
        host_read(32'h00, 32'h42);
        host_read(32'h08, 32'h0001_0000);
        host_write(32'h00, 32'h66);

        // Zero count and over-range count.
        host_write(32'h04, 32'd0);
        host_write(32'h00, 32'h1);
        host_read(32'h00, 32'h2);
        chk("cnt0_busy", 69'(seq_busy), 69'd0);
        host_write(32'h00, 32'h66);
        host_write(32'h04, 32'd9);
        host_read(32'h04, 32'd9);
        host_write(32'h00, 32'h1);
        host_read(32'h00, 32'h6);
        host_write(32'h00, 32'h66);

        // Reset mid-POLL, then a clean run.
        host_write(32'h04, 32'd1);
        host_write(32'h10, 32'h700);
        host_write(32'h14, 32'd8);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h700));
        exp_m.push_back(mw(32'h04, 32'h8));
        exp_m.push_back(mw(32'h08, 32'h1));
        host_write(32'h00, 32'h1);
        wait_master(32'h08, 32'h1, 20);
        step();
        step();
        host_if.req_addr = 32'h00;
        rst = 1'b1;
        #1;
        chk("rst_mid_m_valid", 69'(dma_if.req_valid), 69'd0);
        chk("rst_mid_m_addr", 69'(dma_if.req_addr), 69'd0);
        chk("rst_mid_busy", 69'(seq_busy), 69'd0);
        chk("rst_mid_rdata", 69'(host_if.rdata), 69'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        host_read(32'h04, 32'h0);
        host_write(32'h04, 32'd1);
        host_write(32'h10, 32'h800);
        host_write(32'h14, 32'd2);
        exp_m.push_back(mw(32'h08, 32'h6));
        exp_m.push_back(mw(32'h00, 32'h800));
        exp_m.push_back(mw(32'h04, 32'h2));
        exp_m.push_back(mw(32'h08, 32'h1));
        exp_m.push_back(mw(32'h08, 32'h6));
        host_write(32'h00, 32'h1);
        wait_idle(100);
        host_read(32'h00, 32'h2);
        host_read(32'h08, 32'h0001_0000);

        repeat (3) step();
        chk("exp_m_drained", 69'(exp_m.size()), 69'd0);
        chk("exp_r_drained", 69'(exp_r.size()), 69'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_seq_ctrl.md
Name: dma_seq_ctrl

Overview:
- Descriptor-chain sequencer that drives dma_engine's register port as a bus master.
- Holds up to NUM_DESC (src_addr, len_words) descriptors. For each one in turn: programs dma_engine, starts it, polls DONE/ERR/BUSY, clears the sticky status, then moves on.
- Lets the host queue several wl_bitmap bursts (e.g. one per timestep) from data_sram into input_fifo with a single START.
- Sits between the host register bus and dma_engine's req_* slave port.

Parameters:
- NUM_DESC, 4, descriptor slots (1..8).
- TIMEOUT_CYC, 4096, maximum POLL cycles per descriptor before a timeout error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  host access strobe
- req_write  in  1  1 = write
- req_addr  in  32  byte offset; only [7:0] decoded
- req_wdata  in  32  host write data
- req_wstrb  in  4  byte strobes; apply to DESC_SRC/DESC_LEN only
- rdata  out  32  combinational read data for req_addr
- m_req_valid  out  1  strobe to dma_engine
- m_req_write  out  1  write to dma_engine
- m_req_addr  out  32  dma_engine offset: 0x00, 0x04 or 0x08
- m_req_wdata  out  32  data to dma_engine
- m_req_wstrb  out  4  always 4'hF when m_req_valid
- m_rdata  in  32  dma_engine combinational read data
- seq_busy  out  1  high whenever state != IDLE
- seq_irq  out  1  level output = seq_done_sticky

Behaviour:
- Register map:
  - 0x00 SEQ_CTRL: bit0 START (W1P), bit1 DONE (W1C), bit2 ERR_DMA (W1C), bit3 BUSY (RO), bit4 ABORT (W1P), bit5 ERR_TIMEOUT (W1C), bit6 ABORTED (W1C).
  - 0x04 SEQ_COUNT: bits [3:0], RW.
  - 0x08 SEQ_STATUS (RO): [3:0] current index, [19:16] completed count.
  - 0x10+8*i DESC_SRC[i]; 0x14+8*i DESC_LEN[i].
  - Unmapped offsets read 0.
- Host writes to SEQ_COUNT and DESC_* while busy are ignored.
- Reset: all registers 0; state IDLE; m_req_* = 0; seq_busy = 0; seq_irq = 0. Reset asserted mid-sequence aborts immediately; no clean-up traffic is sent to dma_engine.
- m_req_* outputs are combinational from state and are 0 in every state that does not drive them.
- FSM (one master access per cycle):
  - IDLE: START with SEQ_COUNT == 0 → set DONE, stay in IDLE. START with SEQ_COUNT > NUM_DESC → set DONE and ERR_DMA. Otherwise clear DONE/ERR/ABORTED/ERR_TIMEOUT, idx = 0, completed = 0, go to CLR0. START while busy is ignored.
  - CLR0: write 0x08 = 0x6 (clear stale dma DONE/ERR) → WR_SRC.
  - WR_SRC: write 0x00 = DESC_SRC[idx] → WR_LEN.
  - WR_LEN: write 0x04 = DESC_LEN[idx] → WR_GO.
  - WR_GO: write 0x08 = 0x1; reset the timeout counter → POLL.
  - POLL: m_req_valid = 0, m_req_addr = 0x08; sample m_rdata in the same cycle. When bit1 = 1 and bit3 = 0 → CLR. Otherwise increment the counter; when it reaches TIMEOUT_CYC, set ERR_TIMEOUT and DONE → IDLE. dma_engine is left running; no CLR is issued.
  - CLR: write 0x08 = 0x6. If the sampled bit2 was 1, set ERR_DMA and DONE → IDLE. Otherwise completed++ → NEXT.
  - NEXT: if abort_pending, set ABORTED and DONE → IDLE. Else if idx+1 == SEQ_COUNT, set DONE → IDLE. Else idx++ → WR_SRC.
- ABORT takes effect only at the NEXT boundary, because dma_engine has no cancel. ABORT latches abort_pending (cleared on entry to IDLE); ABORT in IDLE is a no-op.
- Per-descriptor overhead: 3 write cycles + ≥1 POLL + 1 CLR + 1 NEXT.
- A host W1C write in the same cycle as a hardware set: the set wins.

Test Plan:
- COUNT = 2; DESC0 = (0x100, 4), DESC1 = (0x200, 2); START → master write sequence 0x08←6, 0x00←0x100, 0x04←4, 0x08←1, polls, 0x08←6, 0x00←0x200, …; DONE = 1, completed = 2, ERR = 0, seq_irq = 1.
- DESC0 len = 3 (odd), COUNT = 1 → dma_engine reports DONE+ERR on its first poll; ERR_DMA = 1, DONE = 1, completed = 0.
- Hold input_fifo full so dma_engine stays busy, TIMEOUT_CYC = 16 → ERR_TIMEOUT set exactly 16 POLL cycles after WR_GO; BUSY drops next cycle.
- COUNT = 3; ABORT asserted during descriptor 0's POLL → descriptor 0 completes, no write to 0x00 follows; ABORTED = 1, completed = 1.
- START with COUNT = 0 → DONE = 1 next cycle with no master traffic. START with COUNT = 9 → DONE+ERR_DMA. DESC write while busy → readback unchanged.
- Assert rst mid-POLL → all outputs 0 immediately; after release, a START runs cleanly from CLR0.
